// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: forwards WB mtc0 writes onto Status/Cause/EPC and picks one exception by priority.
// Latency: int_i to int_sync_o takes SYNC_STAGES cycles; the exception decision is combinational in the take cycle.
// Backpressure: a stalled MEM slot is held off until the first unstalled cycle; one SETTLE cycle masks takes after each flush.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [7:0]  mem_flags_i,
  input  logic [31:0] mem_ld_addr_i,
  input  logic        stall_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [5:0]  int_sync_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] inst_addr_o,
  output logic        in_ds_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic {IDLE, SETTLE} state_t;
  state_t state, state_nxt;

  logic [5:0]  sync_q [SYNC_STAGES];
  logic [31:0] fwd_status, fwd_cause, fwd_epc;
  logic        int_pending, take;
  logic [31:0] exc_code;

  // Multi-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign int_sync_o = sync_q[SYNC_STAGES-1];

  // Overlay the in-flight WB mtc0 write so decisions see the value CP0 is about to hold
  always_comb begin
    fwd_status = cp0_status_i;
    fwd_epc    = cp0_epc_i;
    fwd_cause  = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == REG_STATUS) fwd_status = wb_cp0_wdata_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == REG_EPC)    fwd_epc    = wb_cp0_wdata_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == REG_CAUSE)  fwd_cause[9:8] = wb_cp0_wdata_i[9:8];
    fwd_cause[15:10] = int_sync_o;
  end

  // Status[0]=IE, Status[1]=EXL, Status[15:8]=IM
  assign int_pending = fwd_status[0] & ~fwd_status[1] &
                       (|(fwd_cause[15:8] & fwd_status[15:8]));

  // Bubbles, stalls, SETTLE and reset all suppress a take
  assign take = (state == IDLE) & mem_valid_i & ~stall_i & ~rst;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: one masked cycle after every committed exception
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE && exc_code != 32'd0) state_nxt = SETTLE;
  end

  // FSM outputs: priority pick and CP0/redirect drive in the take cycle
  always_comb begin
    exc_code     = 32'd0;
    excepttype_o = 32'd0;
    inst_addr_o  = 32'd0;
    in_ds_o      = 1'b0;
    bad_addr_o   = 32'd0;
    flush_o      = 1'b0;
    new_pc_o     = 32'd0;
    if (take) begin
      if (int_pending)         exc_code = 32'h1;
      else if (mem_flags_i[0]) exc_code = 32'h4;
      else if (mem_flags_i[1]) exc_code = 32'ha;
      else if (mem_flags_i[2]) exc_code = 32'h8;
      else if (mem_flags_i[3]) exc_code = 32'h9;
      else if (mem_flags_i[4]) exc_code = 32'hc;
      else if (mem_flags_i[5]) exc_code = 32'h4;
      else if (mem_flags_i[6]) exc_code = 32'h5;
      else if (mem_flags_i[7]) exc_code = 32'he;

      if (exc_code != 32'd0) begin
        excepttype_o = exc_code;
        inst_addr_o  = mem_pc_i;
        in_ds_o      = mem_in_ds_i;
        flush_o      = 1'b1;
        new_pc_o     = (exc_code == 32'he) ? fwd_epc : EXC_VECTOR;
        // Fetch AdEL faults on the PC; data-side AdEL/AdES fault on the effective address
        if (!int_pending && mem_flags_i[0])
          bad_addr_o = mem_pc_i;
        else if (exc_code == 32'h4 || exc_code == 32'h5)
          bad_addr_o = mem_ld_addr_i;
      end
    end
  end

  // Register bits the arbiter never looks at
  logic unused_bits;
  assign unused_bits = ^{fwd_status[31:16], fwd_status[7:2], fwd_cause[31:16],
                         fwd_cause[7:0], cp0_cause_i[15:10]};

endmodule
